motor_cmd_stepper: RTL and testbench

- Consumes the 96-bit command frame assembled by the SPI slave and drives three stepper/DC axes: Z (pulses/pin1/pin2), X (pulsesx/pin1x/pin2x) and Y (pulsesy/pin1y/pin2y).
- Each axis produces a programmed number of step pulses at a programmed rate and drives H-bridge direction pins.
- Honours the global ESTOP and a per-axis dead_end limit switch.
- Sits directly downstream of the SPI slave, in the i_Clk domain.

---
 rtl/motor_cmd_pkg.sv | 36 +++
 rtl/motor_cmd_stepper_axis.sv | 101 ++++++++++
 rtl/motor_cmd_stepper.sv | 65 ++++++
 tb/tb_motor_cmd_stepper.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/motor_cmd_pkg.sv
// Shared encodings for the motor command stepper: axis word layout, frame slicing and axis FSM states.
package motor_cmd_pkg;
    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_FWD   = 2'b01;
    localparam logic [1:0] MODE_REV   = 2'b10;
    localparam logic [1:0] MODE_BRAKE = 2'b11;

    localparam int MODE_MSB = 31;
    localparam int MODE_LSB = 30;
    localparam int CNT_MSB  = 29;
    localparam int CNT_LSB  = 16;
    localparam int HALF_MSB = 15;
    localparam int CNT_W    = 14;
    localparam int HALF_W   = 16;
    localparam int AXIS_W   = 32;

    localparam int AXIS_Z_LSB = 64;
    localparam int AXIS_X_LSB = 32;
    localparam int AXIS_Y_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } axis_state_t;

    // Returns {pin1, pin2} for the H-bridge.
    function automatic logic [1:0] pin_decode(input logic [1:0] mode);
        case (mode)
            MODE_FWD:   return 2'b10;
            MODE_REV:   return 2'b01;
            MODE_BRAKE: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction
endpackage

// File: rtl/motor_cmd_stepper_axis.sv
// One stepper/DC axis: step pulse generator, H-bridge pin decode and limit-switch synchronizer.
//   state   | meaning
//   IDLE    | no motion; pins hold the loaded mode (STOP/BRAKE/refused load) or 00
//   HIGH    | step pulse high phase, counting down the half-period
//   LOW     | step pulse low phase; step count decremented at its end
module step_axis
    import motor_cmd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HALF    = 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [AXIS_W-1:0] word,
    input  logic              load,
    input  logic              kill,
    input  logic              dead_end,
    output logic              pulse,
    output logic              pin1,
    output logic              pin2,
    output logic              busy
);
    logic [SYNC_STAGES-1:0] dead_sync;
    logic                   dead_s;
    axis_state_t            state;
    logic [HALF_W-1:0]      half_in, heff_in, hreload, hcnt;
    logic [CNT_W-1:0]       n_in, ncnt;
    logic [1:0]             mode_in;

    assign mode_in = word[MODE_MSB:MODE_LSB];
    assign n_in    = word[CNT_MSB:CNT_LSB];
    assign half_in = word[HALF_MSB:0];
    assign heff_in = (half_in < HALF_W'(MIN_HALF)) ? HALF_W'(MIN_HALF) : half_in;
    assign dead_s  = dead_sync[SYNC_STAGES-1];
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) dead_sync <= '0;
        else          dead_sync <= {dead_sync[SYNC_STAGES-2:0], dead_end};
    end

    // Pulse trails the HIGH state by one clock so the load edge always drives it low.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state   <= ST_IDLE;
            pulse   <= 1'b0;
            pin1    <= 1'b0;
            pin2    <= 1'b0;
            hreload <= '0;
            hcnt    <= '0;
            ncnt    <= '0;
        end else if (kill || dead_s) begin
            state <= ST_IDLE;
            pulse <= 1'b0;
            pin1  <= 1'b0;
            pin2  <= 1'b0;
            hcnt  <= '0;
            ncnt  <= '0;
        end else if (load) begin
            pulse        <= 1'b0;
            {pin1, pin2} <= pin_decode(mode_in);
            hreload      <= heff_in - HALF_W'(1);
            hcnt         <= heff_in - HALF_W'(1);
            ncnt         <= n_in;
            if ((mode_in == MODE_FWD || mode_in == MODE_REV) && n_in != '0)
                state <= ST_HIGH;
            else
                state <= ST_IDLE;
        end else begin
            case (state)
                ST_HIGH: begin
                    pulse <= 1'b1;
                    if (hcnt == '0) begin
                        state <= ST_LOW;
                        hcnt  <= hreload;
                    end else begin
                        hcnt <= hcnt - HALF_W'(1);
                    end
                end
                ST_LOW: begin
                    pulse <= 1'b0;
                    if (hcnt == '0) begin
                        if (ncnt == CNT_W'(1)) begin
                            state <= ST_IDLE;
                            ncnt  <= '0;
                            pin1  <= 1'b0;
                            pin2  <= 1'b0;
                        end else begin
                            state <= ST_HIGH;
                            ncnt  <= ncnt - CNT_W'(1);
                            hcnt  <= hreload;
                        end
                    end else begin
                        hcnt <= hcnt - HALF_W'(1);
                    end
                end
                default: pulse <= 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/motor_cmd_stepper.sv
// Command-frame change detection, ESTOP synchronizer/fault latch, and three step_axis instances (Z, X, Y).
module motor_cmd_stepper
    import motor_cmd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HALF    = 1
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic [95:0] data_out,
    input  logic        ESTOP,
    input  logic        dead_end,
    input  logic        dead_endx,
    input  logic        dead_endy,
    output logic        pulses,
    output logic        pulsesx,
    output logic        pulsesy,
    output logic        pin1,
    output logic        pin2,
    output logic        pin1x,
    output logic        pin2x,
    output logic        pin1y,
    output logic        pin2y,
    output logic [2:0]  o_Busy,
    output logic        o_Fault
);
    logic [95:0]            prev_frame;
    logic [SYNC_STAGES-1:0] estop_sync;
    logic                   estop_s, new_cmd, load;
    logic                   busy_z, busy_x, busy_y;

    assign new_cmd = (data_out != prev_frame);
    assign estop_s = estop_sync[SYNC_STAGES-1];
    // A changed frame seen while ESTOP is high is consumed and discarded.
    assign load    = new_cmd && !estop_s;
    assign o_Busy  = {busy_z, busy_x, busy_y};

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            prev_frame <= '0;
            estop_sync <= '0;
            o_Fault    <= 1'b0;
        end else begin
            prev_frame <= data_out;
            estop_sync <= {estop_sync[SYNC_STAGES-2:0], ESTOP};
            if (estop_s)      o_Fault <= 1'b1;
            else if (new_cmd) o_Fault <= 1'b0;
        end
    end

    step_axis #(.SYNC_STAGES(SYNC_STAGES), .MIN_HALF(MIN_HALF)) u_axis_z (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .word(data_out[AXIS_Z_LSB +: AXIS_W]),
        .load(load), .kill(estop_s), .dead_end(dead_end),
        .pulse(pulses), .pin1(pin1), .pin2(pin2), .busy(busy_z));

    step_axis #(.SYNC_STAGES(SYNC_STAGES), .MIN_HALF(MIN_HALF)) u_axis_x (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .word(data_out[AXIS_X_LSB +: AXIS_W]),
        .load(load), .kill(estop_s), .dead_end(dead_endx),
        .pulse(pulsesx), .pin1(pin1x), .pin2(pin2x), .busy(busy_x));

    step_axis #(.SYNC_STAGES(SYNC_STAGES), .MIN_HALF(MIN_HALF)) u_axis_y (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .word(data_out[AXIS_Y_LSB +: AXIS_W]),
        .load(load), .kill(estop_s), .dead_end(dead_endy),
        .pulse(pulsesy), .pin1(pin1y), .pin2(pin2y), .busy(busy_y));
endmodule

// File: tb/tb_motor_cmd_stepper.sv
// Directed bench for motor_cmd_stepper with hand-computed expectations.
module tb_motor_cmd_stepper;
    logic        i_Clk = 1'b0;
    logic        i_Rst_L = 1'b0;
    logic [95:0] data_out = '0;
    logic        ESTOP = 1'b0;
    logic        dead_end = 1'b0, dead_endx = 1'b0, dead_endy = 1'b0;
    logic        pulses, pulsesx, pulsesy;
    logic        pin1, pin2, pin1x, pin2x, pin1y, pin2y;
    logic [2:0]  o_Busy;
    logic        o_Fault;

    int total = 0;
    int bad   = 0;

    motor_cmd_stepper #(.SYNC_STAGES(2), .MIN_HALF(1)) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .data_out(data_out), .ESTOP(ESTOP),
        .dead_end(dead_end), .dead_endx(dead_endx), .dead_endy(dead_endy),
        .pulses(pulses), .pulsesx(pulsesx), .pulsesy(pulsesy),
        .pin1(pin1), .pin2(pin2), .pin1x(pin1x), .pin2x(pin2x), .pin1y(pin1y), .pin2y(pin2y),
        .o_Busy(o_Busy), .o_Fault(o_Fault));

    always #5 i_Clk = ~i_Clk;

    task automatic step(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {20'd0, pulses, pulsesx, pulsesy, pin1, pin2, pin1x, pin2x, pin1y, pin2y, o_Busy};
    endfunction

    initial begin
        logic [31:0] exp_p;
        // reset state
        #2;
        chk("rst_outs", outs(), 32'd0);
        chk("rst_fault", {31'd0, o_Fault}, 32'd0);
        step(1);
        i_Rst_L = 1'b1;
        step(3);
        chk("idle_outs", outs(), 32'd0);

        // Z: FWD N=3 H=4; load edge 1, pulse high on edges 2-5, 10-13, 18-21; idle at 25
        data_out = {32'h4003_0004, 32'h0, 32'h0};
        for (int e = 1; e <= 27; e++) begin
            step(1);
            exp_p = (e >= 2 && e <= 21 && ((e - 2) % 8) < 4) ? 32'd1 : 32'd0;
            chk("z_pulse", {31'd0, pulses}, exp_p);
            if (e == 1) begin
                chk("z_pins_fwd", {30'd0, pin1, pin2}, 32'd2);
                chk("z_busy_start", {29'd0, o_Busy}, 32'd4);
            end
            if (e == 24) chk("z_busy_last", {29'd0, o_Busy}, 32'd4);
            if (e == 25) begin
                chk("z_busy_done", {29'd0, o_Busy}, 32'd0);
                chk("z_pins_done", {30'd0, pin1, pin2}, 32'd0);
            end
        end

        // X: REV N=2 H=0 clamps to 1; Y: BRAKE N=0 holds pins with no pulses
        data_out = {32'h0, 32'h8002_0000, 32'hC000_0000};
        for (int e = 1; e <= 6; e++) begin
            step(1);
            exp_p = (e == 2 || e == 4) ? 32'd1 : 32'd0;
            chk("x_pulse", {31'd0, pulsesx}, exp_p);
            chk("y_pulse", {31'd0, pulsesy}, 32'd0);
            if (e == 1) begin
                chk("x_pins_rev", {30'd0, pin1x, pin2x}, 32'd1);
                chk("y_pins_brake", {30'd0, pin1y, pin2y}, 32'd3);
                chk("xy_busy", {29'd0, o_Busy}, 32'd2);
            end
            if (e == 5) chk("x_done", {27'd0, o_Busy, pin1x, pin2x}, 32'd0);
        end
        chk("y_pins_hold", {30'd0, pin1y, pin2y}, 32'd3);

        // dead_end aborts a long Z run and refuses new loads while high
        data_out = {32'h4064_000A, 32'h0, 32'h0};
        step(50);
        chk("z_run_busy", {28'd0, o_Busy, pin1}, 32'h9);
        dead_end = 1'b1;
        step(3);
        chk("dead_abort", outs(), 32'd0);
        data_out = {32'h4005_0002, 32'h0, 32'h0};
        step(4);
        chk("dead_refuse", outs(), 32'd0);
        dead_end = 1'b0;
        step(3);

        // ESTOP with all axes running
        data_out = {32'h4032_0003, 32'h8032_0002, 32'h4032_0001};
        step(10);
        chk("all_busy", {29'd0, o_Busy}, 32'd7);
        ESTOP = 1'b1;
        step(3);
        chk("estop_outs", outs(), 32'd0);
        chk("estop_fault", {31'd0, o_Fault}, 32'd1);
        data_out = {32'h4032_0004, 32'h8032_0002, 32'h4032_0001};
        step(5);
        chk("estop_ignore", {28'd0, o_Busy, o_Fault}, 32'd1);
        ESTOP = 1'b0;
        step(4);
        chk("fault_latched", {28'd0, o_Busy, o_Fault}, 32'd1);
        data_out = {32'h4032_0005, 32'h8032_0002, 32'h4032_0001};
        step(1);
        chk("fault_clear", {31'd0, o_Fault}, 32'd0);
        chk("restart_busy", {29'd0, o_Busy}, 32'd7);
        chk("restart_pins", {28'd0, pin1, pin2, pin1x, pin2x}, 32'h9);

        // identical re-send does not restart; Z pulse high 2-6, low 7-11, high 12-16
        data_out = {32'h4014_0005, 32'h4014_0005, 32'h4014_0005};
        step(1);
        chk("reload_low", {29'd0, pulses, pulsesx, pulsesy}, 32'd0);
        step(2);
        data_out = {32'h4014_0005, 32'h4014_0005, 32'h4014_0005};
        step(1);
        chk("same_e4", {31'd0, pulses}, 32'd1);
        step(3);
        chk("same_e7", {31'd0, pulses}, 32'd0);
        step(5);
        chk("same_e12", {31'd0, pulses}, 32'd1);
        step(1);
        chk("same_e13", {29'd0, pulses, pulsesx, pulsesy}, 32'd7);

        // change only X H: every axis reloads, pulse low on the load cycle
        data_out = {32'h4014_0005, 32'h4014_0006, 32'h4014_0005};
        step(1);
        chk("xh_load_low", {29'd0, pulses, pulsesx, pulsesy}, 32'd0);
        chk("xh_busy", {29'd0, o_Busy}, 32'd7);
        step(1);
        chk("xh_rise", {29'd0, pulses, pulsesx, pulsesy}, 32'd7);

        // asynchronous reset mid-pulse, then restart from prev=0
        #2;
        i_Rst_L = 1'b0;
        #1;
        chk("async_rst", outs(), 32'd0);
        #3;
        i_Rst_L = 1'b1;
        step(1);
        chk("post_rst_busy", {29'd0, o_Busy}, 32'd7);
        chk("post_rst_low", {31'd0, pulses}, 32'd0);
        step(1);
        chk("post_rst_rise", {29'd0, pulses, pulsesx, pulsesy}, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
